// File: rtl/shift_ctrl_if.sv
// Request/response bundle for shift_ctrl: one shift request in, one result word out.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the source holds its payload stable from valid rising until that edge.
interface shift_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic             req_dir;
    logic [1:0]       req_op;
    logic             req_fill;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    modport master (
        output req_valid, req_dir, req_op, req_fill, req_data, req_amt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_dir, req_op, req_fill, req_data, req_amt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/shift_ctrl.sv
// Multi-cycle shift sequencer: one 1-bit shift per clock, result returned over valid/ready.
// Optional macro SHIFT_ROTATE_EN builds rotate for op 11; without it op 11 acts as logical shift.
module shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_ctrl_if.slave bus,
    output logic [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_op;
    logic             r_fill;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_busy;

    logic             w_in_bit;
    logic [WIDTH-1:0] w_shifted;

    always_comb begin
        w_in_bit = 1'b0;
        case (r_op)
            2'b01:   w_in_bit = r_fill;
            2'b10:   w_in_bit = r_dir ? r_work[WIDTH-1] : 1'b0;
`ifdef SHIFT_ROTATE_EN
            2'b11:   w_in_bit = r_dir ? r_work[0] : r_work[WIDTH-1];
`endif
            default: w_in_bit = 1'b0;
        endcase
        w_shifted = r_dir ? {w_in_bit, r_work[WIDTH-1:1]}
                          : {r_work[WIDTH-2:0], w_in_bit};
    end

    // Handshake flags are registered alongside the state so they never depend on req_valid/rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_op        <= 2'b00;
            r_fill      <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_work      <= bus.req_data;
                        r_dir       <= bus.req_dir;
                        r_op        <= bus.req_op;
                        r_fill      <= bus.req_fill;
                        r_cnt       <= bus.req_amt;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.req_amt != '0) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_work;
    assign bus.busy      = r_busy;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_shift_ctrl.sv
// Directed + random bench for shift_ctrl (WIDTH=8, AMT_W=3); honours SHIFT_ROTATE_EN when defined.
module tb_shift_ctrl;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         cyc;
    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    shift_ctrl_if #(.WIDTH(8), .AMT_W(3)) bus ();

    shift_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic dir,
                                         input logic [1:0] op, input logic fill, input int amt);
        logic [7:0] v;
        v = d;
        for (int i = 0; i < amt; i++) begin
            case (op)
                2'b00:   v = dir ? (v >> 1) : (v << 1);
                2'b01:   v = dir ? {fill, v[7:1]} : {v[6:0], fill};
                2'b10:   v = dir ? 8'($signed(v) >>> 1) : (v << 1);
`ifdef SHIFT_ROTATE_EN
                default: v = dir ? {v[0], v[7:1]} : {v[6:0], v[7]};
`else
                default: v = dir ? (v >> 1) : (v << 1);
`endif
            endcase
        end
        return v;
    endfunction

    // Scoreboard: every completed response handshake pops one expected word.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [7:0] d, input logic dir, input logic [1:0] op,
                        input logic fill, input logic [2:0] amt, input logic [7:0] expv,
                        input logic keep, output int acc);
        int ok;
        ok = 0;
        acc = 0;
        bus.req_data  = d;
        bus.req_dir   = dir;
        bus.req_op    = op;
        bus.req_fill  = fill;
        bus.req_amt   = amt;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 60 && ok == 0; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok  = 1;
                acc = cyc + 1;
                exp_q.push_back(expv);
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_valid(input int acc, output int lat);
        int ok;
        ok = 0;
        lat = -1;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok  = 1;
                lat = cyc - acc;
            end
        end
        check("valid_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
        end
        check("idle_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int acc2;
        int lat;
        int seen;
        logic [7:0] rd;
        logic       rdir;
        logic [1:0] rop;
        logic       rfill;
        logic [2:0] ramt;

        cyc = 0; checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_dir = 1'b0; bus.req_op = 2'b00; bus.req_fill = 1'b0;
        bus.req_data = 8'h00; bus.req_amt = 3'd0; bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Left logical by 3, with latency
        send(8'b10101010, 1'b0, 2'b00, 1'b0, 3'd3, 8'b01010000, 1'b0, acc);
        @(negedge clk);
        check("shift_busy", 32'(bus.busy), 32'd1);
        check("shift_req_ready", 32'(bus.req_ready), 32'd0);
        check("shift_state", 32'(dbg_state), 32'd1);
        wait_valid(acc, lat);
        check("lat_amt3", 32'(lat), 32'd3);
        check("done_state", 32'(dbg_state), 32'd2);
        @(posedge clk); #1;

        send(8'b11001101, 1'b1, 2'b01, 1'b1, 3'd2, 8'b11110011, 1'b0, acc);
        wait_valid(acc, lat);
        check("lat_amt2", 32'(lat), 32'd2);
        @(posedge clk); #1;

        send(8'b10010000, 1'b1, 2'b10, 1'b0, 3'd3, 8'b11110010, 1'b0, acc);
        wait_valid(acc, lat);
        @(posedge clk); #1;

`ifdef SHIFT_ROTATE_EN
        send(8'b11001101, 1'b0, 2'b11, 1'b0, 3'd3, 8'b01101110, 1'b0, acc);
`else
        send(8'b11001101, 1'b0, 2'b11, 1'b0, 3'd3, 8'b01101000, 1'b0, acc);
`endif
        wait_valid(acc, lat);
        @(posedge clk); #1;

        // Amount 0 with consumer stalled; req_valid pulses must be ignored
        bus.rsp_ready = 1'b0;
        send(8'hA5, 1'b0, 2'b00, 1'b0, 3'd0, 8'hA5, 1'b0, acc);
        wait_valid(acc, lat);
        check("lat_amt0", 32'(lat), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.req_valid = (i % 2 == 0);
            bus.req_data  = 8'h11;
            bus.req_amt   = 3'd0;
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(bus.rsp_data), 32'hA5);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_idle", 32'(dbg_state), 32'd0);
        check("release_req_ready", 32'(bus.req_ready), 32'd1);
        check("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Reset mid-SHIFT discards the operation
        send(8'hFF, 1'b0, 2'b00, 1'b0, 3'd5, 8'h00, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_rsp_data", 32'(bus.rsp_data), 32'h00);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("no_rsp_after_rst", 32'(seen), 32'd0);
        @(posedge clk); #1;
        send(8'h3C, 1'b1, 2'b00, 1'b0, 3'd1, 8'h1E, 1'b0, acc);
        wait_valid(acc, lat);
        check("lat_amt1", 32'(lat), 32'd1);
        @(posedge clk); #1;

        // Back-to-back with valid and ready held high
        send(8'h81, 1'b0, 2'b00, 1'b0, 3'd1, 8'h02, 1'b1, acc);
        send(8'h81, 1'b1, 2'b10, 1'b0, 3'd2, 8'hE0, 1'b0, acc2);
        check("b2b_spacing", 32'(acc2 - acc), 32'd3);
        wait_valid(acc2, lat);
        check("b2b_lat", 32'(lat), 32'd2);
        @(posedge clk); #1;

        // Random operations with random consumer stalls
        for (int n = 0; n < 24; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rdir  = 1'($urandom_range(0, 1));
            rop   = 2'($urandom_range(0, 3));
            rfill = 1'($urandom_range(0, 1));
            ramt  = 3'($urandom_range(0, 7));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            send(rd, rdir, rop, rfill, ramt, model(rd, rdir, rop, rfill, int'(ramt)), 1'b0, acc);
            repeat ($urandom_range(0, 10)) @(posedge clk);
            #1;
            bus.rsp_ready = 1'b1;
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Multi-cycle shift sequencer for the ALU's serial shift datapath. Accepts a shift request (word, direction, mode, amount) over a valid/ready handshake, performs one single-bit shift per clock in an internal WIDTH-bit working register, and returns the result over a second valid/ready handshake. Sits between the ALU op decoder and the result mux. It replaces ad-hoc per-cycle driving of `dir`/`inp` with one request per complete shift.

## Interface
- `WIDTH`, 8, data word width (≥2)
- `AMT_W`, 3, shift-amount width; amounts 0..2^AMT_W-1 are legal
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_dir`  in  1  0 = left (toward MSB), 1 = right (toward LSB)
- `req_op`  in  2  fill/mode select:
  - 00 logical, fill 0
  - 01 fill with `req_fill`
  - 10 arithmetic: right replicates MSB, left fills 0
  - 11 rotate
- `req_fill`  in  1  fill bit for op 01
- `req_data`  in  WIDTH  operand
- `req_amt`  in  AMT_W  number of single-bit shifts
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_data`  out  WIDTH  result word
- `busy`  out  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready` at a rising edge, capture `req_data` into the working register. Also capture `req_dir`, `req_op`, `req_fill` into mode registers and `req_amt` into the down-counter.
  - Next state is SHIFT if `req_amt`≠0, otherwise DONE.
- SHIFT:
  - Each edge performs exactly one 1-bit shift of the working register per the latched dir/op and decrements the counter.
  - When the counter is 1 at the edge, go to DONE.
  - Request inputs are ignored.
- DONE:
  - `rsp_valid`=1. `rsp_data` is held stable.
  - On `rsp_valid`&&`rsp_ready` at an edge, go to IDLE.
- Incoming bit per mode:
  - op 00: 0.
  - op 01: latched fill bit.
  - op 10, right: current MSB.
  - op 10, left: 0.
  - op 11: the bit shifted out at the other end.
- Amounts ≥WIDTH (only possible when AMT_W > log2 WIDTH) are executed literally. They are not truncated modulo WIDTH.
- `rsp_data` always reflects the working register. It is defined for the consumer only while `rsp_valid`=1.
- No same-edge response-consume plus new-request accept: `req_ready`=0 in DONE.

## Timing
- Reset (async, `rst_n`=0), effective immediately and held while low:
  - state IDLE, working register 0, counter 0.
  - `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- Reset asserted mid-SHIFT or mid-DONE discards the operation. No response is produced.
- `req_ready`, `rsp_valid`, `busy` are decoded from state registers only. They have no combinational path from `req_valid` or `rsp_ready`.
- Latency: accept at edge E0 → `rsp_valid` high after edge E0+N, where N = `req_amt`. For N=0, valid after E0.
- Back-to-back throughput: one operation per N+2 cycles with `rsp_ready` held high.
- `rsp_ready` low in DONE holds `rsp_valid`=1 and `rsp_data` unchanged indefinitely.

## Configuration
- Macro `SHIFT_ROTATE_EN`.
- Defined: op 11 rotates as specified.
- Undefined: no rotate logic is built, and op 11 behaves exactly as op 00 (logical, fill 0).

## Test plan
- WIDTH=8: left, op 00, data 8'b10101010, amt 3 → `rsp_data`=8'b01010000, `rsp_valid` rises after accept edge +3.
- Right, op 01, fill 1, data 8'b11001101, amt 2 → 8'b11110011. Right, op 10, data 8'b10010000, amt 3 → 8'b11110010.
- Left, op 11, data 8'b11001101, amt 3 → 8'b01101110 with `SHIFT_ROTATE_EN`, 8'b01101000 without.
- Data 8'hA5, amt 0 with `rsp_ready`=0 for 5 cycles:
  - `rsp_valid`=1 one edge after accept; `rsp_data`=8'hA5 held.
  - `req_ready`=0; `req_valid` pulses ignored.
  - Raising `rsp_ready` returns to IDLE next edge.
- `rst_n` pulsed low during SHIFT of amt 5 → immediately `rsp_valid`=0, `busy`=0, `req_ready`=1, `rsp_data`=0. No response after release. Next request completes normally.
- Two back-to-back requests (amt 1, amt 2) with `req_valid` and `rsp_ready` held high → accepts 3 cycles apart, results in request order.
